// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction, captures the one-cycle SRAM read word,
// extracts/extends load data and drives the WB pipeline bus and the ID forwarding bus.
module mem_stage #(
    parameter int EXE_TO_MEM_WD = 74,
    parameter int MEM_TO_WB_WD  = 70,
    parameter int MEM_TO_ID_WD  = 39
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_allowin,
    output logic                     mem_allowin,
    input  logic                     exe_to_mem_valid,
    input  logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus,
    output logic                     mem_to_wb_valid,
    output logic [MEM_TO_WB_WD-1:0]  mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0]  mem_to_id_bus,
    input  logic [31:0]              data_sram_rdata
);

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ld_op_e;

    logic                     mem_valid;
    logic                     mem_ready_go;
    logic                     mem_enter;
    logic [EXE_TO_MEM_WD-1:0] exe_to_mem_bus_r;
    logic [31:0]              rdata_buf;
    logic                     rbuf_valid;

    logic [2:0]  ld_op;
    logic        reg_w;
    logic [4:0]  reg_w_addr;
    logic        res_from_mem;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [31:0] eff_rdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign {ld_op, reg_w, reg_w_addr, res_from_mem, alu_result, pc} = exe_to_mem_bus_r;

    assign mem_ready_go    = 1'b1;
    assign mem_allowin     = ~mem_valid | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid & mem_ready_go;
    assign mem_enter       = mem_allowin & exe_to_mem_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid <= 1'b0;
        end else if (mem_allowin) begin
            mem_valid <= exe_to_mem_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_to_mem_bus_r <= '0;
        end else if (mem_enter) begin
            exe_to_mem_bus_r <= exe_to_mem_bus;
        end
    end

    // The SRAM word lives for one cycle only; keep it while the instruction stalls.
    // A new instruction entering takes priority over capturing for the leaving one.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf  <= 32'd0;
            rbuf_valid <= 1'b0;
        end else if (mem_enter) begin
            rbuf_valid <= 1'b0;
        end else if (mem_valid && res_from_mem && !rbuf_valid) begin
            rdata_buf  <= data_sram_rdata;
            rbuf_valid <= 1'b1;
        end
    end

    assign eff_rdata = rbuf_valid ? rdata_buf : data_sram_rdata;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        ld_byte   = eff_rdata[7:0];
        ld_half   = alu_result[1] ? eff_rdata[31:16] : eff_rdata[15:0];
        load_data = eff_rdata;
        case (alu_result[1:0])
            2'd0:    ld_byte = eff_rdata[7:0];
            2'd1:    ld_byte = eff_rdata[15:8];
            2'd2:    ld_byte = eff_rdata[23:16];
            default: ld_byte = eff_rdata[31:24];
        endcase
        case (ld_op)
            LD_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   load_data = {24'd0, ld_byte};
            LD_H:    load_data = {{16{ld_half[15]}}, ld_half};
            LD_HU:   load_data = {16'd0, ld_half};
            default: load_data = eff_rdata;
        endcase
    end

    assign final_result = res_from_mem ? load_data : alu_result;

    assign mem_to_wb_bus = {reg_w, reg_w_addr, final_result, pc};
    assign mem_to_id_bus = {mem_valid, reg_w, reg_w_addr, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, loads, extraction, stalls and
// reset during a stall, with hand-computed expectations.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        wb_allowin;
    logic        mem_allowin;
    logic        exe_to_mem_valid;
    logic [73:0] exe_to_mem_bus;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_bus;
    logic [38:0] mem_to_id_bus;
    logic [31:0] data_sram_rdata;

    int total;
    int bad;

    mem_stage dut (
        .clk              (clk),
        .reset            (reset),
        .wb_allowin       (wb_allowin),
        .mem_allowin      (mem_allowin),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_to_mem_bus   (exe_to_mem_bus),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .mem_to_id_bus    (mem_to_id_bus),
        .data_sram_rdata  (data_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [73:0] mk_bus(input logic [2:0] op, input logic w,
                                           input logic [4:0] waddr, input logic rfm,
                                           input logic [31:0] alu, input logic [31:0] pc);
        return {op, w, waddr, rfm, alu, pc};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        exe_to_mem_valid = 1'b0;
        wb_allowin       = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        exe_to_mem_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        total++;
        if (mem_to_wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_wb_valid: got %b want 0", mem_to_wb_valid);
        end
        total++;
        if (mem_allowin !== 1'b1) begin
            bad++;
            $display("FAIL reset_allowin: got %b want 1", mem_allowin);
        end
        total++;
        if (mem_to_id_bus !== 39'd0) begin
            bad++;
            $display("FAIL reset_id_bus: got %h want 0", mem_to_id_bus);
        end
        total++;
        if (mem_to_wb_bus !== 70'd0) begin
            bad++;
            $display("FAIL reset_wb_bus: got %h want 0", mem_to_wb_bus);
        end
    endtask

    task automatic test_word_load();
        wb_allowin       = 1'b1;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk_bus(3'd0, 1'b1, 5'd5, 1'b1, 32'h0000_1000, 32'h1c00_0010);
        step();
        exe_to_mem_valid = 1'b0;
        data_sram_rdata  = 32'hDEAD_BEEF;
        #1;
        total++;
        if (mem_to_wb_valid !== 1'b1) begin
            bad++;
            $display("FAIL word_wb_valid: got %b want 1", mem_to_wb_valid);
        end
        total++;
        if (mem_to_wb_bus !== {1'b1, 5'd5, 32'hDEAD_BEEF, 32'h1c00_0010}) begin
            bad++;
            $display("FAIL word_wb_bus: got %h want %h", mem_to_wb_bus,
                     {1'b1, 5'd5, 32'hDEAD_BEEF, 32'h1c00_0010});
        end
        total++;
        if (mem_to_id_bus !== {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL word_id_bus: got %h want %h", mem_to_id_bus,
                     {1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF});
        end
        step();
        total++;
        if (mem_to_wb_valid !== 1'b0 || mem_to_id_bus[38] !== 1'b0) begin
            bad++;
            $display("FAIL word_leaves: got valid=%b id38=%b want 0/0",
                     mem_to_wb_valid, mem_to_id_bus[38]);
        end
    endtask

    task automatic test_extract();
        logic [2:0]  ops [7] = '{3'd1, 3'd2, 3'd1, 3'd3, 3'd4, 3'd3, 3'd5};
        logic [1:0]  offs[7] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3, 2'd2};
        logic [31:0] exps[7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F,
                                 32'hFFFF_80F1, 32'h0000_7F02, 32'hFFFF_80F1,
                                 32'h80F1_7F02};
        wb_allowin      = 1'b1;
        data_sram_rdata = 32'h80F1_7F02;
        for (int i = 0; i < 7; i++) begin
            exe_to_mem_valid = 1'b1;
            exe_to_mem_bus   = mk_bus(ops[i], 1'b1, 5'(i + 1), 1'b1,
                                      {30'h0000_0400, offs[i]}, 32'h1c00_0100 + 32'(4 * i));
            step();
            exe_to_mem_valid = 1'b0;
            total++;
            if (mem_to_wb_bus[63:32] !== exps[i]) begin
                bad++;
                $display("FAIL extract_%0d op=%0d a=%0d: got %h want %h",
                         i, ops[i], offs[i], mem_to_wb_bus[63:32], exps[i]);
            end
        end
        drain();
    endtask

    task automatic test_stall();
        logic [69:0] exp_bus;
        exp_bus = {1'b1, 5'd7, 32'h1111_1111, 32'h1c00_0020};
        wb_allowin       = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk_bus(3'd0, 1'b1, 5'd7, 1'b1, 32'h0000_2000, 32'h1c00_0020);
        step();
        // A follow-on load waits in EXE for the whole stall.
        exe_to_mem_bus  = mk_bus(3'd0, 1'b1, 5'd8, 1'b1, 32'h0000_2004, 32'h1c00_0024);
        data_sram_rdata = 32'h1111_1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (mem_to_wb_bus !== exp_bus) begin
                bad++;
                $display("FAIL stall_bus_c%0d: got %h want %h", c, mem_to_wb_bus, exp_bus);
            end
            total++;
            if (mem_allowin !== 1'b0) begin
                bad++;
                $display("FAIL stall_allowin_c%0d: got %b want 0", c, mem_allowin);
            end
            step();
            data_sram_rdata = 32'h2222_2222;
        end
        wb_allowin = 1'b1;
        #1;
        total++;
        if (mem_allowin !== 1'b1 || mem_to_wb_valid !== 1'b1 || mem_to_wb_bus !== exp_bus) begin
            bad++;
            $display("FAIL stall_release: got allowin=%b valid=%b bus=%h want 1/1/%h",
                     mem_allowin, mem_to_wb_valid, mem_to_wb_bus, exp_bus);
        end
        step();
        exe_to_mem_valid = 1'b0;
        data_sram_rdata  = 32'h3333_3333;
        #1;
        total++;
        if (mem_to_wb_bus !== {1'b1, 5'd8, 32'h3333_3333, 32'h1c00_0024}) begin
            bad++;
            $display("FAIL stall_next_entry: got %h want %h", mem_to_wb_bus,
                     {1'b1, 5'd8, 32'h3333_3333, 32'h1c00_0024});
        end
        drain();
    endtask

    task automatic test_back_to_back();
        wb_allowin       = 1'b1;
        data_sram_rdata  = 32'hFFFF_FFFF;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk_bus(3'd0, 1'b1, 5'd9, 1'b0, 32'h1234_5678, 32'h1c00_0040);
        step();
        exe_to_mem_bus   = mk_bus(3'd0, 1'b1, 5'd10, 1'b1, 32'h0000_3000, 32'h1c00_0044);
        total++;
        if (mem_to_wb_bus !== {1'b1, 5'd9, 32'h1234_5678, 32'h1c00_0040}) begin
            bad++;
            $display("FAIL alu_path: got %h want %h", mem_to_wb_bus,
                     {1'b1, 5'd9, 32'h1234_5678, 32'h1c00_0040});
        end
        step();
        // Load A is in MEM while load B enters on the same edge.
        exe_to_mem_bus  = mk_bus(3'd0, 1'b0, 5'd11, 1'b1, 32'h0000_3004, 32'h1c00_0048);
        data_sram_rdata = 32'h4444_4444;
        #1;
        total++;
        if (mem_to_wb_bus !== {1'b1, 5'd10, 32'h4444_4444, 32'h1c00_0044}) begin
            bad++;
            $display("FAIL b2b_load_a: got %h want %h", mem_to_wb_bus,
                     {1'b1, 5'd10, 32'h4444_4444, 32'h1c00_0044});
        end
        step();
        exe_to_mem_valid = 1'b0;
        data_sram_rdata  = 32'h5555_5555;
        #1;
        total++;
        if (mem_to_wb_bus !== {1'b0, 5'd11, 32'h5555_5555, 32'h1c00_0048}) begin
            bad++;
            $display("FAIL b2b_load_b: got %h want %h", mem_to_wb_bus,
                     {1'b0, 5'd11, 32'h5555_5555, 32'h1c00_0048});
        end
        drain();
    endtask

    task automatic test_reset_in_stall();
        wb_allowin       = 1'b0;
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk_bus(3'd0, 1'b1, 5'd12, 1'b1, 32'h0000_4000, 32'h1c00_0060);
        step();
        exe_to_mem_valid = 1'b0;
        data_sram_rdata  = 32'h6666_6666;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (mem_to_wb_valid !== 1'b0 || mem_to_id_bus !== 39'd0) begin
            bad++;
            $display("FAIL reset_stall: got valid=%b id=%h want 0/0",
                     mem_to_wb_valid, mem_to_id_bus);
        end
        total++;
        if (mem_allowin !== 1'b1) begin
            bad++;
            $display("FAIL reset_stall_allowin: got %b want 1", mem_allowin);
        end
        exe_to_mem_valid = 1'b1;
        exe_to_mem_bus   = mk_bus(3'd0, 1'b1, 5'd13, 1'b1, 32'h0000_4004, 32'h1c00_0064);
        step();
        exe_to_mem_valid = 1'b0;
        data_sram_rdata  = 32'h7777_7777;
        #1;
        total++;
        if (mem_to_wb_bus[63:32] !== 32'h7777_7777) begin
            bad++;
            $display("FAIL reset_stall_reload: got %h want 77777777", mem_to_wb_bus[63:32]);
        end
        drain();
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        reset            = 1'b1;
        wb_allowin       = 1'b1;
        exe_to_mem_valid = 1'b0;
        exe_to_mem_bus   = '0;
        data_sram_rdata  = 32'd0;
        test_reset();
        test_word_load();
        test_extract();
        test_stall();
        test_back_to_back();
        test_reset_in_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
